// File: rtl/hack_pkg.sv
// Shared decode constants and helpers for the Hack CPU and its ALU.
package hack_pkg;

  // Instruction field positions
  localparam int INSTR_C    = 15;
  localparam int A_SEL      = 12;
  localparam int ALU_CTL_HI = 11;
  localparam int ALU_CTL_LO = 6;
  localparam int DEST_HI    = 5;
  localparam int DEST_LO    = 3;
  localparam int JMP_HI     = 2;
  localparam int JMP_LO     = 0;

  // Destination bit indices within the full instruction word
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  // Jump condition bit indices within the 3-bit jump field
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  // ALU control bit indices within the 6-bit control field
  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  // Common comp codes
  localparam logic [5:0] COMP_ZERO     = 6'b101010;
  localparam logic [5:0] COMP_D        = 6'b001100;
  localparam logic [5:0] COMP_A        = 6'b110000;
  localparam logic [5:0] COMP_D_PLUS_1 = 6'b011111;

  // Instruction class, selected by the top bit
  typedef enum logic {
    INSTR_KIND_A = 1'b0,
    INSTR_KIND_C = 1'b1
  } instr_kind_e;

  // Decoded view of a compute instruction
  typedef struct packed {
    instr_kind_e kind;
    logic        a_sel;
    logic [5:0]  ctl;
    logic [2:0]  dest;
    logic [2:0]  jmp;
  } instr_dec_t;

  function automatic instr_dec_t decode(input logic [15:0] instr);
    instr_dec_t dec;
    dec.kind  = instr_kind_e'(instr[INSTR_C]);
    dec.a_sel = instr[A_SEL];
    dec.ctl   = instr[ALU_CTL_HI:ALU_CTL_LO];
    dec.dest  = instr[DEST_HI:DEST_LO];
    dec.jmp   = instr[JMP_HI:JMP_LO];
    return dec;
  endfunction

  // Jump decision from the lt/eq/gt mask and the ALU flags
  function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: purely combinational, out = f(x, y, ctl) with zero/negative flags.
module hack_alu
  import hack_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  ctl,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z_s;
  logic [15:0] x_n_s;
  logic [15:0] y_z_s;
  logic [15:0] y_n_s;
  logic [15:0] r_s;

  // Zero/negate each operand, combine by add or and, optionally negate result
  always_comb begin
    if (ctl[CTL_ZX]) begin
      x_z_s = 16'h0000;
    end else begin
      x_z_s = x;
    end
    if (ctl[CTL_NX]) begin
      x_n_s = ~x_z_s;
    end else begin
      x_n_s = x_z_s;
    end
    if (ctl[CTL_ZY]) begin
      y_z_s = 16'h0000;
    end else begin
      y_z_s = y;
    end
    if (ctl[CTL_NY]) begin
      y_n_s = ~y_z_s;
    end else begin
      y_n_s = y_z_s;
    end
    if (ctl[CTL_F]) begin
      r_s = x_n_s + y_n_s;   // modulo 2^16, carry dropped
    end else begin
      r_s = x_n_s & y_n_s;
    end
    if (ctl[CTL_NO]) begin
      out = ~r_s;
    end else begin
      out = r_s;
    end
    zr = (out == 16'h0000);
    ng = out[15];
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle Hack CPU: A, D and PC registers, decode, and the Hack ALU.
module cpu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic [15:0] i_instruction,
  input  logic [15:0] i_ram,
  output logic [15:0] o_ram,
  output logic [15:0] o_pc,
  output logic [15:0] o_ramaddr,
  output logic        o_ram_write,
  output logic [15:0] o_A,
  output logic [15:0] o_D
);

  import hack_pkg::*;

  logic [15:0] a_r;
  logic [15:0] d_r;
  logic [15:0] pc_r;

  instr_dec_t  dec_s;
  logic [15:0] y_s;
  logic [15:0] alu_out_s;
  logic        zr_s;
  logic        ng_s;

  logic [15:0] a_next_s;
  logic [15:0] d_next_s;
  logic [15:0] pc_next_s;
  logic        mem_write_s;

  // Bits 14:13 of a compute instruction carry no meaning
  logic        unused_bits_s;
  assign unused_bits_s = ^i_instruction[14:13];

  assign dec_s = decode(i_instruction);

  hack_alu u_alu (
    .x   (d_r),
    .y   (y_s),
    .ctl (dec_s.ctl),
    .out (alu_out_s),
    .zr  (zr_s),
    .ng  (ng_s)
  );

  // Operand select, next-state and write-strobe decode for the current instruction
  always_comb begin
    a_next_s    = a_r;
    d_next_s    = d_r;
    pc_next_s   = pc_r + 16'h0001;
    mem_write_s = 1'b0;
    if (dec_s.a_sel) begin
      y_s = i_ram;
    end else begin
      y_s = a_r;
    end
    case (dec_s.kind)
      INSTR_KIND_A: begin
        a_next_s = {1'b0, i_instruction[14:0]};
      end
      INSTR_KIND_C: begin
        if (i_instruction[DEST_A]) begin
          a_next_s = alu_out_s;
        end else begin
          a_next_s = a_r;
        end
        if (i_instruction[DEST_D]) begin
          d_next_s = alu_out_s;
        end else begin
          d_next_s = d_r;
        end
        // Jump target is the A value before this instruction's dest write
        if (jump_taken(dec_s.jmp, zr_s, ng_s)) begin
          pc_next_s = a_r;
        end else begin
          pc_next_s = pc_r + 16'h0001;
        end
        mem_write_s = i_instruction[DEST_M] & ~i_reset;
      end
      default: begin
        a_next_s = a_r;
      end
    endcase
  end

  // Register update; reset overrides any jump or dest write in the same cycle
  always_ff @(posedge clk) begin
    if (i_reset) begin
      a_r  <= 16'h0000;
      d_r  <= 16'h0000;
      pc_r <= RESET_PC;
    end else begin
      a_r  <= a_next_s;
      d_r  <= d_next_s;
      pc_r <= pc_next_s;
    end
  end

  assign o_ram       = alu_out_s;
  assign o_pc        = pc_r;
  assign o_ramaddr   = a_r;      // M address is the pre-update A
  assign o_ram_write = mem_write_s;
  assign o_A         = a_r;
  assign o_D         = d_r;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the Hack CPU with an expectation queue.
module tb_cpu;

  logic        clk;
  logic        i_reset;
  logic [15:0] i_instruction;
  logic [15:0] i_ram;
  logic [15:0] o_ram;
  logic [15:0] o_pc;
  logic [15:0] o_ramaddr;
  logic        o_ram_write;
  logic [15:0] o_A;
  logic [15:0] o_D;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        ewr;
    logic        chk_addr;
    logic [15:0] eaddr;
    logic        chk_ram;
    logic [15:0] eram;
    logic [15:0] epc;
    logic [15:0] ea;
    logic [15:0] ed;
  } exp_t;

  exp_t exp_q[$];

  cpu #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_instruction (i_instruction),
    .i_ram         (i_ram),
    .o_ram         (o_ram),
    .o_pc          (o_pc),
    .o_ramaddr     (o_ramaddr),
    .o_ram_write   (o_ram_write),
    .o_A           (o_A),
    .o_D           (o_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One instruction cycle: queue expectations, drive at negedge, check mid-cycle and after posedge
  task automatic step(input string name, input logic rst, input logic [15:0] instr,
                      input logic [15:0] ram_in, input logic ewr,
                      input logic chk_addr, input logic [15:0] eaddr,
                      input logic chk_ram, input logic [15:0] eram,
                      input logic [15:0] epc, input logic [15:0] ea, input logic [15:0] ed);
    exp_t e;
    exp_t got;
    e.ewr = ewr; e.chk_addr = chk_addr; e.eaddr = eaddr;
    e.chk_ram = chk_ram; e.eram = eram; e.epc = epc; e.ea = ea; e.ed = ed;
    @(negedge clk);
    i_reset       = rst;
    i_instruction = instr;
    i_ram         = ram_in;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    chk({name, ".wr"}, {15'h0000, o_ram_write}, {15'h0000, got.ewr});
    if (got.chk_addr) chk({name, ".addr"}, o_ramaddr, got.eaddr);
    if (got.chk_ram)  chk({name, ".ram"},  o_ram,     got.eram);
    @(posedge clk);
    #1;
    chk({name, ".pc"}, o_pc, got.epc);
    chk({name, ".A"},  o_A,  got.ea);
    chk({name, ".D"},  o_D,  got.ed);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_instruction = 16'h0000;
    i_ram         = 16'h0000;

    // Reset held three cycles with random instructions
    for (int i = 0; i < 3; i++) begin
      step("reset", 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    end

    // Store 1234 to the 7-seg
    step("ld1234",  1'b0, 16'h04d2, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h04d2, 16'h0000);
    step("D=A",     1'b0, 16'hec10, 16'h0000, 1'b0, 1'b1, 16'h04d2, 1'b1, 16'h04d2, 16'h0002, 16'h04d2, 16'h04d2);
    step("ld4000",  1'b0, 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h04d2, 1'b0, 16'h0000, 16'h0003, 16'h4000, 16'h04d2);
    step("M=D",     1'b0, 16'he308, 16'h0000, 1'b1, 1'b1, 16'h4000, 1'b1, 16'h04d2, 16'h0004, 16'h4000, 16'h04d2);

    // Tight loop 4 -> 5 -> 4
    step("ld4a",    1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0000, 16'h0005, 16'h0004, 16'h04d2);
    step("jmp_a",   1'b0, 16'he307, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h04d2, 16'h0004, 16'h0004, 16'h04d2);
    step("ld4b",    1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0005, 16'h0004, 16'h04d2);
    step("jmp_b",   1'b0, 16'he307, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h04d2, 16'h0004, 16'h0004, 16'h04d2);

    // ALU sweep with D=5, A=3
    step("ld5",     1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0005, 16'h0005, 16'h04d2);
    step("D=5",     1'b0, 16'hec10, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 16'h0005, 16'h0006, 16'h0005, 16'h0005);
    step("ld3",     1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0007, 16'h0003, 16'h0005);
    step("D-A",     1'b0, 16'he4c0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0002, 16'h0008, 16'h0003, 16'h0005);
    step("A-D",     1'b0, 16'he1c0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'hfffe, 16'h0009, 16'h0003, 16'h0005);
    step("D&A",     1'b0, 16'he000, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0001, 16'h000a, 16'h0003, 16'h0005);
    step("D|A",     1'b0, 16'he540, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0007, 16'h000b, 16'h0003, 16'h0005);
    step("M+1",     1'b0, 16'hfdc0, 16'h0009, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h000a, 16'h000c, 16'h0003, 16'h0005);

    // Conditional jumps with A=0x0020
    step("ld20",    1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h000d, 16'h0020, 16'h0005);
    step("JEQ",     1'b0, 16'hea82, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0000, 16'h0020, 16'h0020, 16'h0005);
    step("JGT",     1'b0, 16'hee81, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b1, 16'hffff, 16'h0021, 16'h0020, 16'h0005);
    step("JLT",     1'b0, 16'hee84, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b1, 16'hffff, 16'h0020, 16'h0020, 16'h0005);

    // AMD=M+1: M written at old A, then A takes the result
    step("ld7",     1'b0, 16'h0007, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0021, 16'h0007, 16'h0005);
    step("AMD",     1'b0, 16'hfdf8, 16'h00ff, 1'b1, 1'b1, 16'h0007, 1'b1, 16'h0100, 16'h0022, 16'h0100, 16'h0100);

    // A-instr max value, ALU sets A[15], PC wraps from 0xFFFF
    step("ld7fff",  1'b0, 16'h7fff, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0023, 16'h7fff, 16'h0100);
    step("A=-1",    1'b0, 16'heea0, 16'h0000, 1'b0, 1'b1, 16'h7fff, 1'b1, 16'hffff, 16'h0024, 16'hffff, 16'h0100);
    step("JMPffff", 1'b0, 16'hea87, 16'h0000, 1'b0, 1'b1, 16'hffff, 1'b1, 16'h0000, 16'hffff, 16'hffff, 16'h0100);
    step("wrap",    1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'hffff, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0100);

    // Reset on a jump + dest-write cycle wins, then execution restarts at RESET_PC
    step("rstjmp",  1'b1, 16'heabf, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step("post",    1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h0003, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
